ahb2_mem_slv: RTL and testbench
===============================

AHB2_MEM_SLV -- requirements
Module: ahb2_mem_slv

Interface
REQ-001 Parameter MEM_BYTES, default 32'h0002_0000 (128 KB): memory size; power of two.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 hsel  in  1  slave select from the bus decoder.
REQ-005 haddr  in  32  byte address; only the low log2(MEM_BYTES) bits are used.
REQ-006 htrans  in  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-007 hwrite  in  1  1 = write, 0 = read.
REQ-008 hsize  in  3  transfer size: 0 = byte, 1 = halfword, 2 = word.
REQ-009 hburst, hprot  in  3, 4  accepted; ignored.
REQ-010 hwdata  in  32  write data, valid in the data phase.
REQ-011 hreadyi  in  1  bus-wide HREADY; an address phase is accepted only when this is 1.
REQ-012 hreadyo  out  1  slave ready.
REQ-013 hresp  out  2  response.
REQ-014 hrdata  out  32  read data.

Function
REQ-015 Zero-wait-state slave: hreadyo SHALL be constant 1 and hresp constant 2'b00 (OKAY).
REQ-016 Address-phase acceptance: on a clock edge where hsel & hreadyi & htrans[1] are all 1, register write flag, haddr (masked to memory size), hsize and a valid bit.
- A cycle with IDLE, BUSY or hsel=0 while hreadyi=1 SHALL clear the valid bit.
REQ-017 Write data phase: on the edge ending the data phase (valid & write), write hwdata into the memory with byte enables.
- Word: all four lanes.
- Halfword: lanes {addr[1],0} and {addr[1],1}.
- Byte: lane addr[1:0].
- Little-endian: lane k = hwdata[8k+7:8k].
REQ-018 Read data phase: while valid & !write, hrdata SHALL be, combinationally, the full 32-bit word at the registered address with addr[1:0] ignored; otherwise hrdata SHALL be 0.
REQ-019 Back-to-back transfers SHALL work: the address phase of transfer N+1 overlaps the data phase of transfer N.
REQ-020 A read of an address written by the immediately preceding transfer SHALL return the new data. This holds naturally because the write commits at the edge where the read's address is registered.
REQ-021 Addresses beyond MEM_BYTES SHALL wrap modulo MEM_BYTES.
REQ-022 Simulation backdoor tasks SHALL be provided; they take zero time and do not touch bus state.
- write_word(addr, data): writes the full word at addr & ~3.
- read_word(addr, data): returns the full word at addr & ~3.
- init_mem_with_addr(): sets every word to its own byte address, i.e. word i = 4*i.

Reset
REQ-023 While rst_n = 0, clear the valid bit, the registered write flag, the registered address and the registered size; hrdata SHALL therefore be 0.
REQ-024 Memory contents SHALL NOT be cleared by reset. Reset asserted mid data phase SHALL abort that write, leaving the memory unchanged.

Structure
REQ-025 Shared package ahb2_pkg SHALL hold the htrans and hsize encodings and the OKAY response constant.
REQ-026 Single module plus one natural sub-module ahb2_mem_array: a word array with 4-bit byte-write enable, a synchronous write port and an asynchronous read port.
REQ-027 The bench connects the ports through the shared slave interface, which carries these signals 1:1. A master-side interface carries hbusreq, hgrant, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hrdata, hready and hresp for arbiter-based masters.

Verification
REQ-028 After init_mem_with_addr, a NONSEQ word read at 0x0000_0100 -> hrdata = 0x0000_0100 in the data phase, with hreadyo = 1 and hresp = 0.
REQ-029 Word write 0xDEADBEEF to 0x40, then a back-to-back read of 0x40 -> 0xDEADBEEF; read_word(0x40) also returns 0xDEADBEEF.
REQ-030 Word 0x40 = 0x11223344, then a byte write of 0xAA on lane 2 (addr 0x42, hwdata = 0x00AA0000) -> word reads 0x11AA3344. A halfword write of 0xBEEF to addr 0x40 (hwdata = 0x0000BEEF) -> word reads 0x11AABEEF.
REQ-031 An IDLE cycle and an hsel = 0 cycle with write asserted -> memory unchanged and hrdata = 0. A BUSY inside a burst -> no access.
REQ-032 A 16-beat INCR write burst from 0x1_0000 followed by a read burst -> every word matches.
- A write to 0x2_0010 with MEM_BYTES = 0x2_0000 lands at 0x10 (wrap-around).
REQ-033 Write 0x12345678, assert rst_n = 0 mid-test, then read back after reset -> 0x12345678 retained. A write whose data phase is hit by reset -> not committed.

Source files
------------

// File: rtl/ahb2_pkg.sv
// ahb2_pkg: shared AHB-Lite encodings used by the memory slave and its bench.
//   htrans_e   : transfer types (IDLE/BUSY/NONSEQ/SEQ)
//   hsize_e    : transfer sizes (byte/halfword/word)
//   HRESP_OKAY : the only response this slave ever returns
//   byte_en()  : 4-bit lane enable for a size/address-offset pair
package ahb2_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    localparam logic [1:0] HRESP_OKAY = 2'b00;

    // Little-endian lane selection; sizes above word fall back to all lanes.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] ofs);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << ofs;
            HSIZE_HALF: be = ofs[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb2_if.sv
// ahb2_slv_if: slave-side AHB signal bundle, 1:1 with the ahb2_mem_slv ports
//   (clk, rst_n, hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
//   hreadyi in; hreadyo, hresp, hrdata out).
// ahb2_mst_if: master-side bundle for arbiter-based masters (hbusreq/hgrant
//   plus the address/data/response signals).
interface ahb2_slv_if;
    logic        clk;
    logic        rst_n;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hreadyi;
    logic        hreadyo;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    modport slave (
        input  clk, rst_n, hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hreadyi,
        output hreadyo, hresp, hrdata
    );
    modport master (
        input  clk, rst_n, hreadyo, hresp, hrdata,
        output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hreadyi
    );
endinterface

interface ahb2_mst_if;
    logic        clk;
    logic        rst_n;
    logic        hbusreq;
    logic        hgrant;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic [1:0]  hresp;

    modport master (
        input  clk, rst_n, hgrant, hrdata, hready, hresp,
        output hbusreq, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata
    );
endinterface

// File: rtl/ahb2_mem_array.sv
// ahb2_mem_array: word-organised memory with per-byte write enables.
//   clk     : write clock
//   i_be    : byte-lane write enables (lane k = bits 8k+7:8k)
//   i_waddr : word index for the synchronous write port
//   i_wdata : write data
//   i_raddr : word index for the asynchronous read port
//   o_rdata : read data (combinational)
// Contents are never reset. bd_* tasks are simulation backdoors.
module ahb2_mem_array #(
    parameter int unsigned WORDS = 32768,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [WORDS];

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < 4; k++) begin
            if (i_be[k]) r_mem[i_waddr][8*k +: 8] <= i_wdata[8*k +: 8];
        end
    end

    assign o_rdata = r_mem[i_raddr];

    task automatic bd_write(input logic [AW-1:0] idx, input logic [31:0] data);
        r_mem[idx] <= data;
    endtask

    task automatic bd_read(input logic [AW-1:0] idx, output logic [31:0] data);
        data = r_mem[idx];
    endtask

    task automatic bd_init();
        for (int unsigned i = 0; i < WORDS; i++) r_mem[i] <= 32'(i * 4);
    endtask

endmodule

// File: rtl/ahb2_mem_slv.sv
// ahb2_mem_slv: zero-wait-state AHB-Lite memory slave.
//   clk, rst_n         : clock, asynchronous active-low reset
//   hsel/haddr/htrans/hwrite/hsize/hburst/hprot : address phase (hburst, hprot ignored)
//   hwdata             : write data (data phase)
//   hreadyi            : bus HREADY; address phases are taken only when high
//   hreadyo/hresp      : always ready / OKAY
//   hrdata             : read data, 0 outside a read data phase
// Backdoor tasks write_word/read_word/init_mem_with_addr act on the array only.
module ahb2_mem_slv
    import ahb2_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 32'h0002_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic [31:0] hwdata,
    input  logic        hreadyi,
    output logic        hreadyo,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata
);

    localparam int unsigned ADDR_W = $clog2(MEM_BYTES);
    localparam int unsigned WORDS  = MEM_BYTES / 4;

    logic              r_valid;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_size;

    logic              w_accept;
    logic [3:0]        w_be;
    logic [31:0]       w_rdata;
    logic              w_unused;

    // htrans[1] covers NONSEQ and SEQ.
    assign w_accept = hsel & hreadyi & htrans[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_size  <= '0;
        end else if (hreadyi) begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_write <= hwrite;
                r_addr  <= haddr[ADDR_W-1:0];
                r_size  <= hsize;
            end
        end
    end

    // Reset clears r_valid asynchronously, so a write whose data phase is
    // interrupted never reaches the array.
    assign w_be = (r_valid & r_write) ? byte_en(r_size, r_addr[1:0]) : '0;

    ahb2_mem_array #(
        .WORDS (WORDS),
        .AW    (ADDR_W - 2)
    ) u_mem (
        .clk     (clk),
        .i_be    (w_be),
        .i_waddr (r_addr[ADDR_W-1:2]),
        .i_wdata (hwdata),
        .i_raddr (r_addr[ADDR_W-1:2]),
        .o_rdata (w_rdata)
    );

    assign hrdata  = (r_valid & ~r_write) ? w_rdata : '0;
    assign hreadyo = 1'b1;
    assign hresp   = HRESP_OKAY;

    assign w_unused = ^{hburst, hprot, haddr[31:ADDR_W]};

    task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
        u_mem.bd_write(addr[ADDR_W-1:2], data);
    endtask

    task automatic read_word(input logic [31:0] addr, output logic [31:0] data);
        u_mem.bd_read(addr[ADDR_W-1:2], data);
    endtask

    task automatic init_mem_with_addr();
        u_mem.bd_init();
    endtask

endmodule

// File: tb/tb_ahb2_mem_slv.sv
module tb_ahb2_mem_slv;
    import ahb2_pkg::*;

    localparam int unsigned MEM_BYTES = 32'h0002_0000;

    ahb2_slv_if s_if ();

    ahb2_mem_slv #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk     (s_if.clk),
        .rst_n   (s_if.rst_n),
        .hsel    (s_if.hsel),
        .haddr   (s_if.haddr),
        .htrans  (s_if.htrans),
        .hwrite  (s_if.hwrite),
        .hsize   (s_if.hsize),
        .hburst  (s_if.hburst),
        .hprot   (s_if.hprot),
        .hwdata  (s_if.hwdata),
        .hreadyi (s_if.hreadyi),
        .hreadyo (s_if.hreadyo),
        .hresp   (s_if.hresp),
        .hrdata  (s_if.hrdata)
    );

    initial s_if.clk = 1'b0;
    always #5 s_if.clk = ~s_if.clk;

    // Reference memory: a flat little-endian byte array.
    logic [7:0] mb [MEM_BYTES];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Outstanding data phase as the bus protocol defines it.
    logic        p_valid = 1'b0;
    logic        p_write = 1'b0;
    logic [31:0] p_addr  = '0;
    int unsigned p_size  = 0;
    logic [31:0] p_wdata = '0;

    function automatic logic [31:0] mword(input logic [31:0] a);
        int unsigned w;
        w = (a % MEM_BYTES) & ~32'd3;
        return {mb[w+3], mb[w+2], mb[w+1], mb[w]};
    endfunction

    task automatic mwrite(input logic [31:0] a, input int unsigned size, input logic [31:0] d);
        int unsigned n, base, lane;
        n    = 1 << size;
        base = (a % MEM_BYTES) & ~(n - 1);
        for (int unsigned k = 0; k < n; k++) begin
            lane = (base + k) % 4;
            mb[base+k] = d[8*lane +: 8];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: checks the current data phase, presents one
    // address phase, crosses the rising edge, returns at the next negedge.
    task automatic step(input logic sel, input htrans_e trans, input logic wr,
                        input logic [31:0] addr, input int unsigned size,
                        input logic [31:0] wdata, input logic rdy = 1'b1);
        if (p_valid && !p_write) chk("rdata", s_if.hrdata, mword(p_addr));
        else                     chk("rdata_zero", s_if.hrdata, 32'h0);
        chk("ready_resp", {29'h0, s_if.hreadyo, s_if.hresp}, {29'h0, 1'b1, HRESP_OKAY});
        s_if.hwdata  = (p_valid && p_write) ? p_wdata : $urandom;
        s_if.hsel    = sel;
        s_if.htrans  = trans;
        s_if.hwrite  = wr;
        s_if.haddr   = addr;
        s_if.hsize   = 3'(size);
        s_if.hburst  = 3'($urandom);
        s_if.hprot   = 4'($urandom);
        s_if.hreadyi = rdy;
        @(posedge s_if.clk);
        if (p_valid && p_write) mwrite(p_addr, p_size, p_wdata);
        if (rdy) begin
            p_valid = sel && trans[1];
            p_write = wr;
            p_addr  = addr;
            p_size  = size;
            p_wdata = wdata;
        end
        @(negedge s_if.clk);
    endtask

    task automatic idle();
        step(1'b0, HTRANS_IDLE, 1'b0, 32'h0, 0, 32'h0);
    endtask

    task automatic drive_idle();
        s_if.hsel   = 1'b0;
        s_if.htrans = HTRANS_IDLE;
        s_if.hwrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] a;
        int unsigned sz;

        s_if.rst_n   = 1'b0;
        s_if.hreadyi = 1'b1;
        s_if.hwdata  = '0;
        s_if.haddr   = '0;
        s_if.hsize   = '0;
        s_if.hburst  = '0;
        s_if.hprot   = '0;
        drive_idle();
        repeat (2) @(negedge s_if.clk);
        chk("reset_hrdata", s_if.hrdata, 32'h0);
        chk("reset_ready", {31'h0, s_if.hreadyo}, 32'h1);
        chk("reset_hresp", {30'h0, s_if.hresp}, 32'h0);
        s_if.rst_n = 1'b1;
        @(negedge s_if.clk);

        // Backdoor init, mirrored into the model.
        dut.init_mem_with_addr();
        for (int unsigned i = 0; i < MEM_BYTES / 4; i++) mwrite(i * 4, 2, i * 4);
        @(negedge s_if.clk);

        // Word read of an initialised location.
        step(1'b1, HTRANS_NONSEQ, 1'b0, 32'h100, 2, 32'h0);
        chk("init_read_100", s_if.hrdata, 32'h0000_0100);
        idle();

        // Write then back-to-back read.
        step(1'b1, HTRANS_NONSEQ, 1'b1, 32'h40, 2, 32'hDEAD_BEEF);
        step(1'b1, HTRANS_NONSEQ, 1'b0, 32'h40, 2, 32'h0);
        chk("b2b_read_40", s_if.hrdata, 32'hDEAD_BEEF);
        idle();
        dut.read_word(32'h40, d);
        chk("bd_read_40", d, 32'hDEAD_BEEF);

        // Byte and halfword lane writes.
        step(1'b1, HTRANS_NONSEQ, 1'b1, 32'h40, 2, 32'h1122_3344);
        step(1'b1, HTRANS_NONSEQ, 1'b1, 32'h42, 0, 32'h00AA_0000);
        idle();
        dut.read_word(32'h40, d);
        chk("byte_lane2", d, 32'h11AA_3344);
        step(1'b1, HTRANS_NONSEQ, 1'b1, 32'h40, 1, 32'h0000_BEEF);
        step(1'b1, HTRANS_NONSEQ, 1'b0, 32'h40, 2, 32'h0);
        chk("half_lane01", s_if.hrdata, 32'h11AA_BEEF);
        idle();

        // IDLE and deselected cycles with write asserted leave memory alone.
        step(1'b1, HTRANS_IDLE, 1'b1, 32'h40, 2, 32'hFFFF_FFFF);
        step(1'b0, HTRANS_NONSEQ, 1'b1, 32'h40, 2, 32'hFFFF_FFFF);
        idle();
        dut.read_word(32'h40, d);
        chk("idle_nosel_nowrite", d, 32'h11AA_BEEF);

        // BUSY inside a burst performs no access.
        step(1'b1, HTRANS_NONSEQ, 1'b1, 32'h300, 2, 32'h0101_0101);
        step(1'b1, HTRANS_BUSY,   1'b1, 32'h304, 2, 32'hBAD0_BAD0);
        step(1'b1, HTRANS_SEQ,    1'b1, 32'h304, 2, 32'h0202_0202);
        step(1'b1, HTRANS_NONSEQ, 1'b0, 32'h300, 2, 32'h0);
        step(1'b1, HTRANS_SEQ,    1'b0, 32'h304, 2, 32'h0);
        chk("busy_burst_304", s_if.hrdata, 32'h0202_0202);
        idle();

        // 16-beat INCR write burst, then read burst.
        for (int unsigned i = 0; i < 16; i++)
            step(1'b1, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1,
                 32'h1_0000 + 4 * i, 2, $urandom);
        for (int unsigned i = 0; i < 16; i++)
            step(1'b1, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b0,
                 32'h1_0000 + 4 * i, 2, 32'h0);
        idle();

        // Wrap-around beyond MEM_BYTES.
        step(1'b1, HTRANS_NONSEQ, 1'b1, 32'h2_0010, 2, 32'hC0FF_EE11);
        idle();
        dut.read_word(32'h10, d);
        chk("wrap_0x10", d, 32'hC0FF_EE11);
        step(1'b1, HTRANS_NONSEQ, 1'b0, 32'h10, 2, 32'h0);
        idle();

        // Backdoor write observed on the bus.
        dut.write_word(32'h202, 32'hA5A5_5A5A);
        mwrite(32'h200, 2, 32'hA5A5_5A5A);
        @(negedge s_if.clk);
        step(1'b1, HTRANS_NONSEQ, 1'b0, 32'h200, 2, 32'h0);
        chk("bd_write_200", s_if.hrdata, 32'hA5A5_5A5A);
        idle();

        // Randomised traffic, including wrapped addresses and stalled HREADY.
        for (int unsigned i = 0; i < 400; i++) begin
            sz = $urandom_range(0, 2);
            a  = ($urandom & 32'h0006_00FF) & ~((32'd1 << sz) - 1);
            step(($urandom_range(0, 9) != 0), htrans_e'($urandom_range(0, 3)),
                 1'($urandom), a, sz, $urandom,
                 (!p_valid && $urandom_range(0, 4) == 0) ? 1'b0 : 1'b1);
        end
        idle();

        // Retention across reset; reset kills a read data phase at once.
        step(1'b1, HTRANS_NONSEQ, 1'b1, 32'h80, 2, 32'h1234_5678);
        step(1'b1, HTRANS_NONSEQ, 1'b0, 32'h80, 2, 32'h0);
        drive_idle();
        s_if.rst_n = 1'b0;
        #1;
        chk("rst_hrdata_zero", s_if.hrdata, 32'h0);
        repeat (2) @(posedge s_if.clk);
        p_valid = 1'b0;
        @(negedge s_if.clk);
        s_if.rst_n = 1'b1;
        step(1'b1, HTRANS_NONSEQ, 1'b0, 32'h80, 2, 32'h0);
        chk("rst_retain_80", s_if.hrdata, 32'h1234_5678);
        idle();

        // Reset during a write data phase aborts the write.
        dut.write_word(32'h84, 32'h5555_AAAA);
        mwrite(32'h84, 2, 32'h5555_AAAA);
        @(negedge s_if.clk);
        step(1'b1, HTRANS_NONSEQ, 1'b1, 32'h84, 2, 32'hCAFE_F00D);
        s_if.hwdata = p_wdata;
        drive_idle();
        #2 s_if.rst_n = 1'b0;
        @(posedge s_if.clk);
        p_valid = 1'b0;
        @(negedge s_if.clk);
        s_if.rst_n = 1'b1;
        step(1'b1, HTRANS_NONSEQ, 1'b0, 32'h84, 2, 32'h0);
        chk("rst_abort_84", s_if.hrdata, 32'h5555_AAAA);
        idle();
        dut.read_word(32'h84, d);
        chk("bd_rst_abort_84", d, 32'h5555_AAAA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
